usb_transmitter: RTL and testbench

- Full-speed USB bit-level transmitter; the transmit-direction counterpart of the receive path (sync/edge/decode/timer/shift/rcu/rx_fifo).
- Pulls packet bytes from a show-ahead transmit FIFO and serialises them LSB-first.
- Frames each packet as SYNC + data + EOP, with NRZI encoding and bit stuffing.
- Drives d_plus/d_minus directly; one bit period = CLKS_PER_BIT clocks.

---
 rtl/usb_transmitter.sv | 252 +++++++++++++++++++++++++
 tb/tb_usb_transmitter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_transmitter.sv
// ---------------------------------------------------------------------------
// usb_transmitter
//
// Full-speed USB bit-level transmitter. Pulls payload bytes from a show-ahead
// transmit FIFO and sends each packet as SYNC + data + EOP. Bits go out
// LSB-first, NRZI-encoded and bit-stuffed, directly on D+/D-.
// One bit period lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high (lines return to J at once)
//   tx_start    one-cycle send request, sampled only while idle
//   byte_count  payload length in bytes, latched with tx_start and clamped to
//               MAX_BYTES
//   tx_data     head-of-FIFO byte (show-ahead)
//   tx_empty    FIFO empty flag
//   tx_read     one-cycle FIFO pop strobe, one per byte actually sent
//   d_plus      USB D+ line (registered)
//   d_minus     USB D- line (registered)
//   tx_busy     high from the cycle after an accepted tx_start until idle
//   tx_done     one-cycle pulse on return to idle
//   tx_error    sticky FIFO-underflow flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module usb_transmitter #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tx_start,
  input  logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
  input  logic [7:0]                     tx_data,
  input  logic                           tx_empty,
  output logic                           tx_read,
  output logic                           d_plus,
  output logic                           d_minus,
  output logic                           tx_busy,
  output logic                           tx_done,
  output logic                           tx_error
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST_CNT  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_BYTES);

  // SYNC pattern 8'h80: seven zeros and then a one, sent LSB-first. Through
  // NRZI this produces KJKJKJKK on the lines.
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;     // clock position inside a bit period
  logic [2:0]    bit_idx_q, bit_idx_d;     // bit of shift_q on the line; EOP period count
  logic [2:0]    ones_q, ones_d;           // consecutive transmitted ones
  logic          stuffing_q, stuffing_d;   // current period is a stuffed zero
  logic [7:0]    shift_q, shift_d;         // byte being sent (SYNC or payload)
  logic [CW-1:0] remaining_q, remaining_d; // payload bytes not yet finished
  logic          d_plus_q, d_plus_d;
  logic          d_minus_q, d_minus_d;
  logic          tx_read_q, tx_read_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_error_q, tx_error_d;

  logic          bit_end;    // last clock of the current bit period
  logic [2:0]    next_idx;
  logic          send;       // a real (non-stuff) bit starts at this boundary
  logic          tx_bit;     // value of that bit
  logic          level;      // NRZI level for the next period, 1 = J
  logic [CW-1:0] rem_after;

  assign bit_end  = (bit_cnt_q == LAST_CNT);
  assign next_idx = bit_idx_q + 3'd1;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    ones_d      = ones_q;
    stuffing_d  = stuffing_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    d_plus_d    = d_plus_q;
    d_minus_d   = d_minus_q;
    tx_read_d   = 1'b0;
    tx_busy_d   = tx_busy_q;
    tx_done_d   = 1'b0;
    tx_error_d  = tx_error_q;
    send        = 1'b0;
    tx_bit      = 1'b0;
    level       = d_plus_q;
    rem_after   = remaining_q;

    if (state_q != IDLE) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        d_plus_d  = 1'b1;
        d_minus_d = 1'b0;
        if (tx_start) begin
          state_d     = SYNC;
          tx_busy_d   = 1'b1;
          tx_error_d  = 1'b0;
          remaining_d = (byte_count > MAX_COUNT) ? MAX_COUNT : byte_count;
          shift_d     = SYNC_BYTE;
          bit_idx_d   = 3'd0;
          stuffing_d  = 1'b0;
          // First SYNC bit is a zero: toggle from idle J to K right away.
          ones_d      = 3'd0;
          d_plus_d    = 1'b0;
          d_minus_d   = 1'b1;
        end
      end

      SYNC, DATA: begin
        if (bit_end) begin
          if (!stuffing_q && ones_q == 3'd6) begin
            // Six ones in a row: insert a stuffed zero before anything else,
            // including before EOP after the final data bit.
            stuffing_d = 1'b1;
            ones_d     = 3'd0;
            level      = ~d_plus_q;
          end else begin
            stuffing_d = 1'b0;
            if (bit_idx_q != 3'd7) begin
              bit_idx_d = next_idx;
              send      = 1'b1;
              tx_bit    = shift_q[next_idx];
            end else begin
              // Byte boundary. Leaving SYNC finishes no payload byte, so the
              // count is only decremented at the end of a DATA byte.
              rem_after   = (state_q == DATA) ? remaining_q - 1'b1 : remaining_q;
              remaining_d = rem_after;
              if (rem_after == '0) begin
                state_d = EOP_SE0;
              end else if (tx_empty) begin
                tx_error_d = 1'b1;
                state_d    = EOP_SE0;
              end else begin
                state_d   = DATA;
                shift_d   = tx_data;
                bit_idx_d = 3'd0;
                tx_read_d = 1'b1;
                send      = 1'b1;
                tx_bit    = tx_data[0];
              end
            end
          end

          if (send) begin
            // NRZI: a zero toggles the line, a one holds it.
            level  = tx_bit ? d_plus_q : ~d_plus_q;
            ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
          end

          if (state_d == EOP_SE0) begin
            bit_idx_d = 3'd0;
            d_plus_d  = 1'b0;
            d_minus_d = 1'b0;
          end else begin
            d_plus_d  = level;
            d_minus_d = ~level;
          end
        end
      end

      EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd1) begin
            state_d   = EOP_J;
            bit_idx_d = 3'd0;
            d_plus_d  = 1'b1;
            d_minus_d = 1'b0;
          end else begin
            bit_idx_d = next_idx;
          end
        end
      end

      EOP_J: begin
        if (bit_end) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
          tx_busy_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        d_plus_d  = 1'b1;
        d_minus_d = 1'b0;
        tx_busy_d = 1'b0;
      end
    endcase
  end

  // Every flop is reset so an aborted packet leaves no stale state behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      ones_q      <= 3'd0;
      stuffing_q  <= 1'b0;
      shift_q     <= 8'h00;
      remaining_q <= '0;
      d_plus_q    <= 1'b1;
      d_minus_q   <= 1'b0;
      tx_read_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      ones_q      <= ones_d;
      stuffing_q  <= stuffing_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      d_plus_q    <= d_plus_d;
      d_minus_q   <= d_minus_d;
      tx_read_q   <= tx_read_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
      tx_error_q  <= tx_error_d;
    end
  end

  assign d_plus   = d_plus_q;
  assign d_minus  = d_minus_q;
  assign tx_read  = tx_read_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;
  assign tx_error = tx_error_q;

endmodule

// File: tb/tb_usb_transmitter.sv
// ---------------------------------------------------------------------------
// tb_usb_transmitter
//
// Bench for usb_transmitter. A queue models the show-ahead FIFO. For every
// packet, a reference model builds the expected line symbol per bit period
// directly from the framing rules: SYNC bits, payload bits, NRZI, stuffing
// after six ones, and SE0 SE0 J. It also builds the expected pop positions
// and the expected underflow flag. Directed vectors come from a table with
// hand-derived packet lengths; randomized packets follow.
// ---------------------------------------------------------------------------
module tb_usb_transmitter;

  localparam int CPB   = 8;
  localparam int MAXB  = 64;
  localparam int LIMIT = 6000;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [6:0] byte_count;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_read;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo[$];
  logic [7:0] pkt_bytes[$];
  logic [1:0] exp_syms[$];
  int         exp_reads[$];
  bit         exp_err;
  bit         m_lvl;
  int         m_ones;

  always #5 clk = ~clk;

  usb_transmitter #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .byte_count (byte_count),
    .tx_data    (tx_data),
    .tx_empty   (tx_empty),
    .tx_read    (tx_read),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fifo_sync();
    tx_empty = (fifo.size() == 0);
    tx_data  = tx_empty ? 8'h00 : fifo[0];
  endtask

  // Reference model: one transmitted bit, plus its stuff bit if it completes
  // a run of six ones.
  task automatic send_bit(input bit b);
    if (!b) begin
      m_lvl  = ~m_lvl;
      m_ones = 0;
    end else begin
      m_ones++;
    end
    exp_syms.push_back(m_lvl ? LJ : LK);
    if (m_ones == 6) begin
      m_lvl  = ~m_lvl;
      m_ones = 0;
      exp_syms.push_back(m_lvl ? LJ : LK);
    end
  endtask

  task automatic build_expected(input int count);
    int n;
    logic [7:0] cur;
    n = (count > MAXB) ? MAXB : count;
    exp_syms.delete();
    exp_reads.delete();
    exp_err = 1'b0;
    m_lvl   = 1'b1;
    m_ones  = 0;
    for (int i = 0; i < 8; i++) send_bit(i == 7);
    for (int i = 0; i < n; i++) begin
      if (i >= pkt_bytes.size()) begin
        exp_err = 1'b1;
        break;
      end
      exp_reads.push_back(exp_syms.size());
      cur = pkt_bytes[i];
      for (int b = 0; b < 8; b++) send_bit(cur[b]);
    end
    exp_syms.push_back(LSE0);
    exp_syms.push_back(LSE0);
    exp_syms.push_back(LJ);
  endtask

  // Sends one packet with pkt_bytes preloaded in the FIFO and checks it
  // against the model. poke_at >= 0 pulses tx_start at that sample while busy.
  // exp_periods >= 0 also checks the duration against a hand-derived length.
  task automatic run_packet(input string tag, input int count, input int poke_at,
                            input int exp_periods);
    logic [1:0] smp[$];
    int         rd[$];
    int         done_at = -1;
    int         bad_busy = 0, bad_rd = 0, bad_per = 0, bad_pos = 0, first_bad = -1;
    int         idx;
    logic       err0 = 1'b1, busy0 = 1'b0, err_end = 1'b0;
    logic [1:0] line_end = LSE0;

    fifo = pkt_bytes;
    fifo_sync();
    build_expected(count);

    @(negedge clk);
    byte_count = 7'(count);
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start   = 1'b0;

    for (int j = 0; j < LIMIT; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) begin
        err0  = tx_error;
        busy0 = tx_busy;
      end
      tx_start = (j == poke_at);
      if (j == poke_at) byte_count = 7'd5;
      if (tx_done) begin
        done_at  = j;
        err_end  = tx_error;
        line_end = {d_plus, d_minus};
        if (tx_busy) bad_busy++;
        break;
      end
      smp.push_back({d_plus, d_minus});
      if (!tx_busy) bad_busy++;
      if (tx_read) begin
        rd.push_back(j);
        if (tx_empty) bad_rd++;
        else begin
          void'(fifo.pop_front());
          fifo_sync();
        end
      end
    end
    tx_start = 1'b0;

    check({tag, "/finished"}, done_at >= 0, 1);
    check({tag, "/duration"}, done_at, 8 * exp_syms.size());
    if (exp_periods >= 0) check({tag, "/table_duration"}, done_at, CPB * exp_periods);

    for (int k = 0; k < exp_syms.size(); k++) begin
      for (int c = 0; c < CPB; c++) begin
        idx = CPB * k + c;
        if (idx >= smp.size() || smp[idx] !== exp_syms[k]) begin
          bad_per++;
          if (first_bad < 0) first_bad = k;
          break;
        end
      end
    end
    check($sformatf("%s/bad_line_periods(first=%0d)", tag, first_bad), bad_per, 0);

    check({tag, "/read_count"}, rd.size(), exp_reads.size());
    for (int k = 0; k < rd.size() && k < exp_reads.size(); k++)
      if (rd[k] != CPB * exp_reads[k]) bad_pos++;
    check({tag, "/read_positions_bad"}, bad_pos, 0);
    check({tag, "/read_while_empty"}, bad_rd, 0);
    check({tag, "/busy_profile_bad"}, bad_busy, 0);
    check({tag, "/busy_after_start"}, busy0, 1);
    check({tag, "/error_cleared_on_start"}, err0, 0);
    check({tag, "/error_at_done"}, err_end, exp_err);
    check({tag, "/line_at_done"}, line_end, LJ);

    @(negedge clk);
    check({tag, "/error_sticky_idle"}, tx_error, exp_err);
    check({tag, "/busy_idle"}, tx_busy, 0);

    fifo.delete();
    fifo_sync();
  endtask

  typedef struct {
    string      name;
    int         count;
    int         nbytes;
    logic [7:0] pat0;
    logic [7:0] pat1;
    int         poke_at;
    int         periods;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bad;
    int cnt, nb, poke;

    vecs[0] = '{"zero_byte",  0,   0, 8'h00, 8'h00, -1, 11};
    vecs[1] = '{"byte_00",    1,   1, 8'h00, 8'h00, -1, 19};
    vecs[2] = '{"byte_ff",    1,   1, 8'hFF, 8'hFF, -1, 20};
    vecs[3] = '{"bytes_ffff", 2,   2, 8'hFF, 8'hFF, -1, 29};
    vecs[4] = '{"bytes_7ffe", 2,   2, 8'h7F, 8'hFE, -1, 29};
    vecs[5] = '{"underflow",  3,   1, 8'hA5, 8'hA5, 20, 19};
    vecs[6] = '{"clamp_100",  100, 64, 8'h55, 8'h55, -1, 523};

    rst        = 1'b0;
    tx_start   = 1'b0;
    byte_count = 7'd0;
    fifo.delete();
    fifo_sync();

    // Reset asserted mid-cycle, before any clock edge.
    #3 rst = 1'b1;
    #1;
    check("reset/d_plus", d_plus, 1);
    check("reset/d_minus", d_minus, 0);
    check("reset/tx_busy", tx_busy, 0);
    check("reset/tx_read", tx_read, 0);
    check("reset/tx_done", tx_done, 0);
    check("reset/tx_error", tx_error, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({d_plus, d_minus} !== LJ || tx_busy !== 1'b0 || tx_read !== 1'b0 ||
          tx_error !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("reset/idle_hold_bad_cycles", bad, 0);

    foreach (vecs[v]) begin
      pkt_bytes.delete();
      for (int i = 0; i < vecs[v].nbytes; i++)
        pkt_bytes.push_back((i % 2 == 0) ? vecs[v].pat0 : vecs[v].pat1);
      run_packet(vecs[v].name, vecs[v].count, vecs[v].poke_at, vecs[v].periods);
    end

    // Reset in the middle of a packet aborts straight to J with no EOP.
    fifo.delete();
    fifo.push_back(8'hFF);
    fifo.push_back(8'hFF);
    fifo_sync();
    @(negedge clk);
    byte_count = 7'd2;
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start   = 1'b0;
    repeat (100) @(negedge clk) begin
      if (tx_read && !tx_empty) begin
        void'(fifo.pop_front());
        fifo_sync();
      end
    end
    check("abort/busy_before_reset", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort/line_j", {d_plus, d_minus}, LJ);
    check("abort/busy_cleared", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if ({d_plus, d_minus} !== LJ || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("abort/idle_after_bad_cycles", bad, 0);
    fifo.delete();
    fifo_sync();

    // Randomized packets: stuffing-heavy data, occasional underflow and
    // occasional tx_start pulses while busy.
    for (int p = 0; p < 40; p++) begin
      cnt = $urandom_range(0, 5);
      nb  = cnt;
      if (cnt > 0 && $urandom_range(0, 4) == 0) nb = $urandom_range(0, cnt - 1);
      poke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : -1;
      pkt_bytes.delete();
      for (int i = 0; i < nb; i++)
        pkt_bytes.push_back($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
      run_packet($sformatf("rand%0d", p), cnt, poke, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
